// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory responder.
package mem_pkg;

  localparam int unsigned WordWidth = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane handling: store merge into the old word, load extract/extend,
// and size/alignment checking.
module lsu_align
  import mem_pkg::*;
(
  input  logic [1:0]           addr_i,
  input  size_e                size_i,
  input  logic                 unsigned_i,
  input  logic [WordWidth-1:0] wdata_i,
  input  logic [WordWidth-1:0] word_i,
  output logic [WordWidth-1:0] merged_o,
  output logic [WordWidth-1:0] rdata_o,
  output logic                 misalign_o
);

  logic [4:0]           shamt;
  logic [WordWidth-1:0] lane_mask;
  logic [WordWidth-1:0] shifted;
  logic                 sx;

  assign shamt = {addr_i, 3'b000};
  assign sx    = ~unsigned_i;

  always_comb begin
    lane_mask  = '0;
    rdata_o    = '0;
    misalign_o = 1'b0;
    shifted    = word_i >> shamt;
    unique case (size_i)
      SZ_BYTE: begin
        lane_mask = 32'h0000_00ff;
        rdata_o   = {{24{sx & shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        lane_mask  = 32'h0000_ffff;
        rdata_o    = {{16{sx & shifted[15]}}, shifted[15:0]};
        misalign_o = addr_i[0];
      end
      SZ_WORD: begin
        lane_mask  = 32'hffff_ffff;
        rdata_o    = word_i;
        misalign_o = |addr_i;
      end
      SZ_ILL: begin
        misalign_o = 1'b1;
      end
      default: begin
        misalign_o = 1'b1;
      end
    endcase
    // Unselected lanes keep the old word; an illegal size leaves the mask empty.
    merged_o = (word_i & ~(lane_mask << shamt)) | ((wdata_i & lane_mask) << shamt);
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with programmable response latency.
// Holds the word array and the IDLE/WAIT/RESP handshake FSM.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [WordWidth-1:0] req_addr,
  input  logic [WordWidth-1:0] req_wdata,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WordWidth-1:0] rsp_rdata,
  output logic                 rsp_err
);

  localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [WordWidth-1:0] rdata_q, rdata_d;
  logic                 err_q, err_d;

  logic                 we_q, uns_q;
  size_e                size_q;
  logic [WordWidth-1:0] addr_q, wdata_q;

  logic [WordWidth-1:0] mem [DEPTH_WORDS];

  logic                 cur_we, cur_uns;
  size_e                cur_size;
  logic [WordWidth-1:0] cur_addr, cur_wdata;
  logic                 in_range, misalign, err_cur, accept, enter_resp;
  logic [IdxW-1:0]      idx;
  logic [WordWidth-1:0] word_rd, merged, load_data;

  // In IDLE the live request feeds the datapath so LATENCY=1 can resolve on the accept edge.
  always_comb begin
    if (state_q == IDLE) begin
      cur_we    = req_we;
      cur_uns   = req_unsigned;
      cur_size  = size_e'(req_size);
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
    end else begin
      cur_we    = we_q;
      cur_uns   = uns_q;
      cur_size  = size_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
    end
  end

  assign in_range   = {2'b00, cur_addr[WordWidth-1:2]} < DEPTH_WORDS;
  assign idx        = cur_addr[IdxW+1:2];
  assign word_rd    = in_range ? mem[idx] : '0;
  assign err_cur    = misalign | ~in_range;
  assign accept     = req_valid && (state_q == IDLE);
  assign enter_resp = (accept && (LATENCY == 1)) || ((state_q == WAIT) && (cnt_q == 4'd1));

  lsu_align u_align (
    .addr_i     (cur_addr[1:0]),
    .size_i     (cur_size),
    .unsigned_i (cur_uns),
    .wdata_i    (cur_wdata),
    .word_i     (word_rd),
    .merged_o   (merged),
    .rdata_o    (load_data),
    .misalign_o (misalign)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= SZ_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      uns_q   <= req_unsigned;
      size_q  <= size_e'(req_size);
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Array is never reset; rst gates the write so a request seen during reset cannot commit.
  always_ff @(posedge clk) begin
    if (rst && enter_resp && cur_we && !err_cur) begin
      mem[idx] <= merged;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (enter_resp) begin
      err_d   = err_cur;
      rdata_d = (err_cur || cur_we) ? '0 : load_data;
    end
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    rsp_rdata = rdata_q;
    rsp_err   = err_q;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named as below.
REQ-002 The block SHALL have these parameters (name, default, meaning):
- DEPTH_WORDS, 1024, number of 32-bit words in the array.
- LATENCY, 2, cycles from request acceptance to rsp_valid; legal range 1..15.

REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-low reset.
- req_valid, in, 1, request present.
- req_ready, out, 1, responder can accept a request.
- req_we, in, 1, 1 = store, 0 = load.
- req_addr, in, 32, byte address.
- req_wdata, in, 32, store data, right-aligned.
- req_size, in, 2, access size: 00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned, in, 1, load zero-extends when 1, sign-extends when 0.
- rsp_valid, out, 1, response present.
- rsp_ready, in, 1, initiator accepts the response.
- rsp_rdata, out, 32, load result (0 for stores and errors).
- rsp_err, out, 1, request was misaligned, out of range or illegal size.

Function
REQ-004 The FSM SHALL have states IDLE, WAIT and RESP, with one request outstanding at most.
REQ-005 req_ready SHALL be 1 only in IDLE.
REQ-006 A request SHALL be accepted on a rising edge with req_valid=1 and req_ready=1. All req_* fields SHALL be latched at that edge.
REQ-007 On acceptance, the FSM SHALL go to RESP if LATENCY=1. Otherwise it SHALL go to WAIT with the down-counter loaded with LATENCY-1.
REQ-008 In WAIT, the counter SHALL decrement each cycle, and the FSM SHALL move to RESP on the edge where the counter equals 1.
REQ-009 rsp_valid SHALL rise exactly LATENCY cycles after the acceptance edge and SHALL be 1 only in RESP.
REQ-010 In RESP, rsp_rdata and rsp_err SHALL hold stable until an edge with rsp_ready=1. The FSM SHALL then return to IDLE, and req_ready SHALL be 1 in the following cycle.
REQ-011 The store commit and the load read SHALL both occur on the edge that enters RESP.
REQ-012 An error SHALL be flagged for any of: size=11; half with addr[0]=1; word with addr[1:0]≠00; addr[31:2] ≥ DEPTH_WORDS.
REQ-013 An erroring store SHALL leave the array unmodified. An erroring request SHALL return rsp_rdata=0 and rsp_err=1.
REQ-014 A store SHALL write only the addressed lanes:
- byte: lane addr[1:0] ← wdata[7:0].
- half: lanes addr[1]*2 and addr[1]*2+1 ← wdata[15:0].
- word: all four lanes.
REQ-015 A load SHALL extract the addressed lane(s) and right-align them, then zero-extend or sign-extend according to req_unsigned. Word loads SHALL ignore req_unsigned.
REQ-016 A completed store SHALL return rsp_rdata=0 and rsp_err=0.
REQ-017 req_valid while not in IDLE SHALL be ignored and SHALL NOT alter latched fields.
REQ-018 rsp_ready while not in RESP SHALL have no effect.

Reset
REQ-019 While rst=0, the block SHALL hold state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0 and rsp_err=0. req_ready SHALL be 1 after release.
REQ-020 Reset SHALL take effect immediately, independent of clk.
REQ-021 Reset in WAIT or RESP SHALL abandon the request. A pending store SHALL NOT commit if reset asserts before the RESP-entry edge.
REQ-022 Array contents SHALL NOT be reset.

Structure
REQ-023 Package mem_pkg SHALL hold:
- the access-size enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL);
- the FSM state enum;
- the word-width constant 32.
REQ-024 One combinational sub-module, lsu_align, SHALL perform store lane merge, load extract/extend and the misalignment check. The array and FSM SHALL remain in dmem_responder.

Verification
REQ-025 Word store then load: store 0xDEADBEEF at addr 0x10, then load a word at 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, and rsp_valid exactly 2 cycles after each acceptance.
REQ-026 Byte loads over 0x80FF7F01 at 0x20:
- signed byte at 0x22 -> 0xFFFFFFFF;
- unsigned byte at 0x23 -> 0x00000080;
- signed half at 0x22 -> 0xFFFF80FF.
REQ-027 Misaligned and out-of-range requests:
- word store at 0x06 -> rsp_err=1, and a subsequent word load of 0x04 returns the old contents unchanged;
- load at 0x1000 with DEPTH_WORDS=1024 -> rsp_err=1, rsp_rdata=0.
REQ-028 Back-pressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata and req_ready=0 all remain stable. Toggling req_valid during this time is ignored.
REQ-029 Reset mid-operation: pulse rst low during WAIT of a byte store 0xAA to 0x30 -> rsp_valid=0 immediately, and a later load of 0x30 shows the pre-store value.
REQ-030 LATENCY=1 build: run back-to-back requests with rsp_ready tied to 1 -> one accepted request every 2 cycles and rsp_valid one cycle after each acceptance.
